// File: rtl/data_memory_responder.sv
// ============================================================================
// data_memory_responder : word data memory answering CPU LW/SW requests
// Revision: 1.0
// ============================================================================
`default_nettype none

module data_memory_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int         DEPTH    = 2 ** (ADDR_WIDTH - 2);
  localparam int         IDX_W    = ADDR_WIDTH - 2;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic [31:0] mem_q [DEPTH];

  logic             accept;
  logic             addr_err;
  logic [IDX_W-1:0] word_idx;
  logic [31:0]      rd_word;
  logic             mem_we;

  assign accept   = (state_q == ST_IDLE) && req_valid;
  assign word_idx = addr_q[ADDR_WIDTH-1:2];
  assign rd_word  = mem_q[word_idx];
  // Anything above the implemented byte range, or not word aligned, is an error.
  assign addr_err = (addr_q[1:0] != 2'b00) || ((addr_q >> ADDR_WIDTH) != 32'd0);
  assign mem_we   = (state_q == ST_RESP) && write_q && !addr_err;

  // State register and latched request fields
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      write_q <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Store commits on the edge that ends the response cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 32'd0;
      end
    end else if (mem_we) begin
      mem_q[word_idx] <= wdata_q;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (LATENCY == 1) begin
            state_d = ST_RESP;
          end else begin
            cnt_d   = CNT_LOAD;
            state_d = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        if (cnt_q == 4'd1) begin
          cnt_d   = 4'd0;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Outputs decode registered state only, so inputs never reach them directly
  always_comb begin
    req_ready  = (state_q == ST_IDLE);
    resp_valid = (state_q == ST_RESP);
    resp_err   = 1'b0;
    resp_rdata = 32'd0;
    if (state_q == ST_RESP) begin
      resp_err = addr_err;
      if (!write_q && !addr_err) begin
        resp_rdata = rd_word;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_data_memory_responder.sv
// ============================================================================
// tb_data_memory_responder : directed bench for data_memory_responder
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_data_memory_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid [3];
  logic        req_write = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        ready [3];
  logic        rv [3];
  logic [31:0] rdata [3];
  logic        err [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Instance 0: LATENCY=2, instance 1: LATENCY=1, instance 2: LATENCY=5
  data_memory_responder #(.ADDR_WIDTH(10), .LATENCY(2)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid[0]), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(ready[0]),
    .resp_valid(rv[0]), .resp_rdata(rdata[0]), .resp_err(err[0]));

  data_memory_responder #(.ADDR_WIDTH(10), .LATENCY(1)) dut_l1 (
    .clk(clk), .reset(reset), .req_valid(req_valid[1]), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(ready[1]),
    .resp_valid(rv[1]), .resp_rdata(rdata[1]), .resp_err(err[1]));

  data_memory_responder #(.ADDR_WIDTH(10), .LATENCY(5)) dut_l5 (
    .clk(clk), .reset(reset), .req_valid(req_valid[2]), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(ready[2]),
    .resp_valid(rv[2]), .resp_rdata(rdata[2]), .resp_err(err[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction on instance 'which'; latency counted from the accept cycle.
  task automatic xact(input int which, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input int exp_lat,
                      input logic [31:0] exp_rd, input logic exp_err, input string tag);
    int cyc;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_valid[which] = 1'b1;
    chk({tag, ".ready"}, 32'(ready[which]), 32'd1);
    step();
    req_valid[which] = 1'b0;
    cyc = 1;
    while (rv[which] !== 1'b1 && cyc < 20) begin
      step();
      cyc++;
    end
    chk({tag, ".lat"}, 32'(cyc), 32'(exp_lat));
    chk({tag, ".rdata"}, rdata[which], exp_rd);
    chk({tag, ".err"}, 32'(err[which]), 32'(exp_err));
    step();
    chk({tag, ".rv_low"}, 32'(rv[which]), 32'd0);
    chk({tag, ".ready_back"}, 32'(ready[which]), 32'd1);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) req_valid[k] = 1'b0;

    // Reset state
    step();
    step();
    reset = 1'b0;
    chk("rst.ready", 32'(ready[0]), 32'd1);
    chk("rst.rv", 32'(rv[0]), 32'd0);
    chk("rst.rdata", rdata[0], 32'd0);
    chk("rst.err", 32'(err[0]), 32'd0);
    chk("rst.ready_l1", 32'(ready[1]), 32'd1);
    chk("rst.ready_l5", 32'(ready[2]), 32'd1);

    xact(0, 1'b0, 32'h000, 32'h0, 2, 32'h0, 1'b0, "ld0");

    // Highest legal word, then neighbour untouched
    xact(0, 1'b1, 32'h3FC, 32'hDEADBEEF, 2, 32'h0, 1'b0, "st3fc");
    xact(0, 1'b0, 32'h3FC, 32'h0, 2, 32'hDEADBEEF, 1'b0, "ld3fc");
    xact(0, 1'b0, 32'h3F8, 32'h0, 2, 32'h0, 1'b0, "ld3f8");

    // Error cases: misaligned store must not write word 1, out-of-range load
    xact(0, 1'b1, 32'h006, 32'hCAFEF00D, 2, 32'h0, 1'b1, "st006");
    xact(0, 1'b0, 32'h400, 32'h0, 2, 32'h0, 1'b1, "ld400");
    xact(0, 1'b0, 32'h004, 32'h0, 2, 32'h0, 1'b0, "ld004");
    xact(0, 1'b1, 32'h0001_0000, 32'h1, 2, 32'h0, 1'b1, "sthi");

    // Preload words 0x20..0x38 for the back-to-back test
    for (int i = 0; i < 7; i++) begin
      xact(0, 1'b1, 32'h20 + 32'(4 * i), 32'hA000_0000 + 32'(i), 2, 32'h0, 1'b0, "pre");
    end

    // req_valid held high, address moves every cycle; accepts at i=0,3,6
    req_write = 1'b0;
    req_valid[0] = 1'b1;
    for (int i = 0; i < 9; i++) begin
      req_addr = 32'h20 + 32'(4 * i);
      chk("hold.ready", 32'(ready[0]), (i % 3 == 0) ? 32'd1 : 32'd0);
      chk("hold.rv", 32'(rv[0]), (i % 3 == 2) ? 32'd1 : 32'd0);
      if (i % 3 == 2) begin
        chk("hold.rdata", rdata[0], 32'hA000_0000 + 32'(i - 2));
      end
      if (i == 8) req_valid[0] = 1'b0;
      step();
    end
    chk("hold.idle", 32'(ready[0]), 32'd1);

    // Reset during BUSY of a store aborts it
    req_write = 1'b1;
    req_addr  = 32'h010;
    req_wdata = 32'h12345678;
    req_valid[0] = 1'b1;
    step();
    req_valid[0] = 1'b0;
    chk("abort.busy", 32'(ready[0]), 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort.rv", 32'(rv[0]), 32'd0);
    chk("abort.ready", 32'(ready[0]), 32'd1);
    step();
    chk("abort.rv2", 32'(rv[0]), 32'd0);
    xact(0, 1'b0, 32'h010, 32'h0, 2, 32'h0, 1'b0, "ld010");

    // Other latencies
    xact(1, 1'b1, 32'h008, 32'h5555AAAA, 1, 32'h0, 1'b0, "l1st");
    xact(1, 1'b0, 32'h008, 32'h0, 1, 32'h5555AAAA, 1'b0, "l1ld");
    xact(1, 1'b0, 32'h002, 32'h0, 1, 32'h0, 1'b1, "l1err");
    xact(2, 1'b1, 32'h00C, 32'h0BADF00D, 5, 32'h0, 1'b0, "l5st");
    xact(2, 1'b0, 32'h00C, 32'h0, 5, 32'h0BADF00D, 1'b0, "l5ld");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
